// File: rtl/mining_scheduler.sv
// Round-robin scheduler sharing one mine_block between two players; owns chain head and block count.
// Optional MINE watchdog with block_abort output: define MINING_SCHED_TIMEOUT_EN.
//   state  | meaning
//   IDLE   | arbitrate requests, latch winner, pulse its ack
//   LOAD   | hold miner in synchronous reset for RST_CYCLES cycles
//   MINE   | miner enabled; wait for done_mining (ignored in first cycle)
//   COMMIT | publish block, bump count
module mining_scheduler #(
    parameter logic [7:0]  GENESIS_HASH   = 8'h00,
    parameter int unsigned RST_CYCLES     = 3
`ifdef MINING_SCHED_TIMEOUT_EN
    , parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
`endif
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       p1_req,
    input  logic [7:0] p1_signature,
    input  logic [7:0] p1_amount,
    input  logic       p1_direction,
    output logic       p1_ack,
    input  logic       p2_req,
    input  logic [7:0] p2_signature,
    input  logic [7:0] p2_amount,
    input  logic       p2_direction,
    output logic       p2_ack,
    output logic       mine_resetn,
    output logic       mine_enable,
    output logic [7:0] mine_previous_hash,
    output logic [7:0] mine_signature,
    output logic [7:0] mine_amount,
    output logic       mine_direction,
    input  logic       mine_done,
    input  logic [7:0] mine_hash,
    output logic       block_valid,
    output logic [7:0] block_hash,
    output logic       block_owner,
    output logic [7:0] block_count,
`ifdef MINING_SCHED_TIMEOUT_EN
    output logic       block_abort,
`endif
    output logic       busy
);

    localparam int unsigned LOAD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_MINE   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LOAD_W-1:0] r_load_cnt;
    logic              r_mine_settled;
    logic [7:0]        r_chain_head;
    logic [7:0]        r_block_hash;
    logic              r_block_owner;
    logic [7:0]        r_block_count;
    logic              r_cur_owner;
    logic              r_rr_ptr;
    logic [7:0]        r_signature;
    logic [7:0]        r_amount;
    logic              r_direction;

    logic              w_grant_p1;
    logic              w_grant_p2;
    logic              w_done_ok;
    logic              w_timeout;

`ifdef MINING_SCHED_TIMEOUT_EN
    logic [31:0]       r_to_cnt;
    logic              r_block_abort;

    assign w_timeout   = (r_state == S_MINE) && !w_done_ok &&
                         (r_to_cnt == (TIMEOUT_CYCLES - 32'd1));
    assign block_abort = r_block_abort;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_to_cnt      <= 32'd0;
            r_block_abort <= 1'b0;
        end else begin
            r_to_cnt      <= (r_state == S_MINE) ? r_to_cnt + 32'd1 : 32'd0;
            r_block_abort <= w_timeout;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // pointer = 0 favours p1 when both request
    assign w_grant_p1 = (r_state == S_IDLE) && p1_req && (!p2_req || !r_rr_ptr);
    assign w_grant_p2 = (r_state == S_IDLE) && p2_req && (!p1_req ||  r_rr_ptr);
    assign w_done_ok  = (r_state == S_MINE) && r_mine_settled && mine_done;

    always_comb begin
        w_state_nxt = r_state;
        mine_resetn = 1'b0;
        mine_enable = 1'b0;
        block_valid = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_grant_p1 || w_grant_p2) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (r_load_cnt == '0) begin
                    w_state_nxt = S_MINE;
                end
            end
            S_MINE: begin
                mine_resetn = 1'b1;
                mine_enable = 1'b1;
                if (w_done_ok) begin
                    w_state_nxt = S_COMMIT;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_COMMIT: begin
                block_valid = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_load_cnt     <= '0;
            r_mine_settled <= 1'b0;
            r_chain_head   <= GENESIS_HASH;
            r_block_hash   <= 8'h00;
            r_block_owner  <= 1'b0;
            r_block_count  <= 8'h00;
            r_cur_owner    <= 1'b0;
            r_rr_ptr       <= 1'b0;
            r_signature    <= 8'h00;
            r_amount       <= 8'h00;
            r_direction    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_mine_settled <= (r_state == S_MINE);
            if (w_grant_p1) begin
                r_signature <= p1_signature;
                r_amount    <= p1_amount;
                r_direction <= p1_direction;
                r_cur_owner <= 1'b0;
                r_rr_ptr    <= 1'b1;
                r_load_cnt  <= LOAD_W'(RST_CYCLES - 1);
            end else if (w_grant_p2) begin
                r_signature <= p2_signature;
                r_amount    <= p2_amount;
                r_direction <= p2_direction;
                r_cur_owner <= 1'b1;
                r_rr_ptr    <= 1'b0;
                r_load_cnt  <= LOAD_W'(RST_CYCLES - 1);
            end else if ((r_state == S_LOAD) && (r_load_cnt != '0)) begin
                r_load_cnt <= r_load_cnt - 1'b1;
            end
            // hash and count update together so they are already valid in COMMIT
            if (w_done_ok) begin
                r_chain_head  <= mine_hash;
                r_block_hash  <= mine_hash;
                r_block_owner <= r_cur_owner;
                r_block_count <= r_block_count + 8'd1;
            end
        end
    end

    // acks are gated by reset so a held request cannot leak an ack while in reset
    assign p1_ack             = w_grant_p1 & resetn;
    assign p2_ack             = w_grant_p2 & resetn;
    assign mine_previous_hash = r_chain_head;
    assign mine_signature     = r_signature;
    assign mine_amount        = r_amount;
    assign mine_direction     = r_direction;
    assign block_hash         = r_block_hash;
    assign block_owner        = r_block_owner;
    assign block_count        = r_block_count;

endmodule

// File: tb/tb_mining_scheduler.sv
// Directed bench for mining_scheduler with a behavioural miner model.
module tb_mining_scheduler;

    logic       clock = 1'b0;
    logic       resetn;
    logic       p1_req, p2_req;
    logic [7:0] p1_signature, p1_amount, p2_signature, p2_amount;
    logic       p1_direction, p2_direction;
    logic       p1_ack, p2_ack;
    logic       mine_resetn, mine_enable;
    logic [7:0] mine_previous_hash, mine_signature, mine_amount;
    logic       mine_direction;
    logic       mine_done;
    logic [7:0] mine_hash;
    logic       block_valid;
    logic [7:0] block_hash;
    logic       block_owner;
    logic [7:0] block_count;
    logic       busy;
`ifdef MINING_SCHED_TIMEOUT_EN
    logic       block_abort;
`endif

    int checks = 0;
    int errors = 0;

    int         mdl_cnt = 0;
    int         mdl_done_after = 1000000;
    logic [7:0] mdl_hash = 8'h00;

    always #5 clock = ~clock;

    // miner model: counts enabled cycles since its synchronous reset released
    always @(posedge clock) begin
        if (!mine_resetn) mdl_cnt <= 0;
        else              mdl_cnt <= mdl_cnt + 1;
    end
    assign mine_done = mine_enable && ((mdl_cnt + 1) >= mdl_done_after);
    assign mine_hash = mdl_hash;

    mining_scheduler #(
        .GENESIS_HASH(8'h00),
        .RST_CYCLES(3)
`ifdef MINING_SCHED_TIMEOUT_EN
        , .TIMEOUT_CYCLES(32'd50)
`endif
    ) u_dut (
        .clock(clock), .resetn(resetn),
        .p1_req(p1_req), .p1_signature(p1_signature), .p1_amount(p1_amount),
        .p1_direction(p1_direction), .p1_ack(p1_ack),
        .p2_req(p2_req), .p2_signature(p2_signature), .p2_amount(p2_amount),
        .p2_direction(p2_direction), .p2_ack(p2_ack),
        .mine_resetn(mine_resetn), .mine_enable(mine_enable),
        .mine_previous_hash(mine_previous_hash), .mine_signature(mine_signature),
        .mine_amount(mine_amount), .mine_direction(mine_direction),
        .mine_done(mine_done), .mine_hash(mine_hash),
        .block_valid(block_valid), .block_hash(block_hash),
        .block_owner(block_owner), .block_count(block_count),
`ifdef MINING_SCHED_TIMEOUT_EN
        .block_abort(block_abort),
`endif
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    // Called just after a negedge; waits for an ack, then runs the block to block_valid.
    task automatic do_block(input int n_done, input logic [7:0] hash, input bit drop,
                            output int lat, output int rst_lo, output bit owner,
                            output logic [7:0] prev_seen);
        int guard;
        mdl_done_after = n_done;
        mdl_hash       = hash;
        lat = 0; rst_lo = 0; owner = 1'b0; prev_seen = 8'h00;
        guard = 0;
        while (!p1_ack && !p2_ack && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (!p1_ack && !p2_ack) begin
            lat = -1;
            return;
        end
        owner = p2_ack;
        lat   = 1;
        guard = 0;
        do begin
            @(negedge clock);
            if (drop) begin
                p1_req = 1'b0;
                p2_req = 1'b0;
            end
            lat++;
            if (busy && !mine_resetn && !block_valid) rst_lo++;
            if (mine_enable) prev_seen = mine_previous_hash;
            guard++;
        end while (!block_valid && guard < 3000);
        if (!block_valid) lat = -2;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        int         lat, rst_lo, vcnt, badlat, guard, mcnt;
        bit         owner;
        logic [7:0] prev;
        logic [7:0] hashes [4];

        resetn = 1'b0;
        p1_req = 1'b1; p1_signature = 8'hA5; p1_amount = 8'h10; p1_direction = 1'b0;
        p2_req = 1'b0; p2_signature = 8'h22; p2_amount = 8'h33; p2_direction = 1'b1;
        repeat (2) @(negedge clock);

        // reset state, with a request already pending
        check("rst_busy", busy, 0);
        check("rst_mine_resetn", mine_resetn, 0);
        check("rst_mine_enable", mine_enable, 0);
        check("rst_block_valid", block_valid, 0);
        check("rst_block_count", block_count, 0);
        check("rst_block_hash", block_hash, 0);
        check("rst_block_owner", block_owner, 0);
        check("rst_prev_hash", mine_previous_hash, 8'h00);
        check("rst_p1_ack", p1_ack, 0);
        check("rst_signature", mine_signature, 0);

        // single p1 block, done after 20 MINE cycles
        resetn = 1'b1;
        #1;
        check("t1_p1_ack", p1_ack, 1);
        check("t1_p2_ack", p2_ack, 0);
        do_block(20, 8'h3C, 1'b1, lat, rst_lo, owner, prev);
        check("t1_latency", lat, 25);
        check("t1_rst_low", rst_lo, 3);
        check("t1_owner_ack", owner, 0);
        check("t1_prev_during_mine", prev, 8'h00);
        check("t1_block_hash", block_hash, 8'h3C);
        check("t1_block_owner", block_owner, 0);
        check("t1_block_count", block_count, 1);
        p1_signature = 8'hFF;
        @(negedge clock);
        check("t1_valid_pulse", block_valid, 0);
        check("t1_busy_after", busy, 0);
        check("t1_prev_hash", mine_previous_hash, 8'h3C);
        check("t1_sig_latched", mine_signature, 8'hA5);
        check("t1_amt_latched", mine_amount, 8'h10);
        check("t1_dir_latched", mine_direction, 0);

        // round robin, both requests held over four blocks
        do_reset();
        p1_signature = 8'h11;
        p1_req = 1'b1; p2_req = 1'b1;
        #1;
        hashes[0] = 8'h51; hashes[1] = 8'h62; hashes[2] = 8'h73; hashes[3] = 8'h84;
        for (int i = 0; i < 4; i++) begin
            do_block(3, hashes[i], (i == 3), lat, rst_lo, owner, prev);
            check($sformatf("rr_owner_%0d", i), owner, i % 2);
            check($sformatf("rr_block_owner_%0d", i), block_owner, i % 2);
            check($sformatf("rr_sig_%0d", i), mine_signature, (i % 2) ? 8'h22 : 8'h11);
            check($sformatf("rr_prev_%0d", i), prev, (i == 0) ? 8'h00 : hashes[(i + 3) % 4]);
            check($sformatf("rr_latency_%0d", i), lat, 8);
        end
        check("rr_block_count", block_count, 4);
        check("rr_chain_head", mine_previous_hash, 8'h84);

        // done held from first MINE cycle: ignored once, commit on second
        @(negedge clock);
        p1_req = 1'b1;
        #1;
        do_block(1, 8'h99, 1'b1, lat, rst_lo, owner, prev);
        check("early_latency", lat, 7);
        check("early_rst_low", rst_lo, 3);
        check("early_block_hash", block_hash, 8'h99);
        check("early_block_count", block_count, 5);

        // 256 blocks: counter wraps
        @(negedge clock);
        do_reset();
        p1_req = 1'b1;
        #1;
        vcnt = 0; badlat = 0;
        for (int i = 0; i < 256; i++) begin
            do_block(1, 8'h80 ^ 8'(i), (i == 255), lat, rst_lo, owner, prev);
            if (block_valid) vcnt++;
            if (lat != 7) badlat++;
            if (i == 254) check("wrap_count_255", block_count, 8'hFF);
        end
        check("wrap_valid_count", vcnt, 256);
        check("wrap_bad_latency", badlat, 0);
        check("wrap_block_count", block_count, 8'h00);
        check("wrap_block_hash", block_hash, 8'h7F);
        check("wrap_chain_head", mine_previous_hash, 8'h7F);

        // reset in the middle of MINE
        @(negedge clock);
        mdl_done_after = 1000000;
        p2_req = 1'b1;
        guard = 0;
        while (!mine_enable && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        check("mid_reached_mine", mine_enable, 1);
        repeat (5) @(negedge clock);
        resetn = 1'b0;
        #1;
        check("mid_mine_enable", mine_enable, 0);
        check("mid_mine_resetn", mine_resetn, 0);
        check("mid_busy", busy, 0);
        check("mid_chain_head", mine_previous_hash, 8'h00);
        check("mid_block_valid", block_valid, 0);
        check("mid_p2_ack", p2_ack, 0);
        p2_req = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        vcnt = 0; mcnt = 0;
        repeat (30) begin
            @(negedge clock);
            if (block_valid) vcnt++;
            if (busy) mcnt++;
        end
        check("mid_no_valid", vcnt, 0);
        check("mid_stays_idle", mcnt, 0);

`ifdef MINING_SCHED_TIMEOUT_EN
        // watchdog abort after 50 MINE cycles
        p1_req = 1'b1;
        #1;
        do_block(2, 8'h5A, 1'b1, lat, rst_lo, owner, prev);
        check("to_first_block", block_count, 1);
        @(negedge clock);
        mdl_done_after = 1000000;
        p1_req = 1'b1;
        #1;
        check("to_ack", p1_ack, 1);
        mcnt = 0; guard = 0;
        while (!block_abort && guard < 200) begin
            @(negedge clock);
            p1_req = 1'b0;
            if (mine_enable) mcnt++;
            guard++;
        end
        check("to_abort_seen", block_abort, 1);
        check("to_mine_cycles", mcnt, 50);
        check("to_busy", busy, 0);
        check("to_block_count", block_count, 1);
        check("to_chain_head", mine_previous_hash, 8'h5A);
        check("to_block_hash", block_hash, 8'h5A);
        @(negedge clock);
        check("to_abort_pulse", block_abort, 0);
        p2_req = 1'b1;
        #1;
        do_block(4, 8'h6B, 1'b1, lat, rst_lo, owner, prev);
        check("to_next_latency", lat, 9);
        check("to_next_owner", owner, 1);
        check("to_next_prev", prev, 8'h5A);
        check("to_next_count", block_count, 2);
        check("to_next_hash", block_hash, 8'h6B);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
